// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern generator; optional repeat via SEQ_GEN_REPEAT_EN
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int GAP     = 2,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic               repeat_req,
  output logic               w,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               w_d, done_d, err_d;
  logic               len_ok;

`ifdef SEQ_GEN_REPEAT_EN
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  logic [GW-1:0]      gap_q, gap_d;
`else
  logic               unused_cfg;
  assign unused_cfg = repeat_req ^ (GAP > 0);
`endif

  // Bit idx of p, done as a shift so the index width need not match the vector.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] idx);
    logic [MAX_LEN-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));
  assign busy   = (state_q != S_IDLE);

  // Next-state and next registered outputs; w holds the bit selected by the counter.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d   = pattern;
            len_d   = len;
            cnt_d   = len - LW'(1);
            w_d     = bit_at(pattern, len - LW'(1));
            state_d = S_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
          w_d   = bit_at(pat_q, cnt_q - LW'(1));
        end
`ifdef SEQ_GEN_REPEAT_EN
        else if (repeat_req) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP - 1);
          end else begin
            cnt_d = len_q - LW'(1);
            w_d   = bit_at(pat_q, len_q - LW'(1));
          end
        end
`endif
        else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef SEQ_GEN_REPEAT_EN
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = len_q - LW'(1);
          w_d     = bit_at(pat_q, len_q - LW'(1));
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched frame and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      w       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      w       <= w_d;
      done    <= done_d;
      err     <= err_d;
`ifdef SEQ_GEN_REPEAT_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;

  localparam int MAX_LEN = 8;
  localparam int GAP     = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef SEQ_GEN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      len;
  logic               repeat_req;
  logic               w, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [2:0] flg;
    logic       w;
  } ev_t;
  ev_t exp_q[$];

  seq_pattern_gen #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_req (repeat_req),
    .w          (w),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [2:0] f, input logic b);
    ev_t e;
    e.cyc = c;
    e.flg = f;
    e.w   = b;
    exp_q.push_back(e);
  endfunction

  // Monitor: every cycle with busy/done/err must match the next expected event exactly.
  always @(negedge clk) begin
    ev_t e;
    if (!reset_n) begin
      n_tests++;
      if ({w, busy, done, err} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got w/busy/done/err=%b, expected 0000", {w, busy, done, err});
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: expected cyc=%0d flags=%b w=%b, nothing seen by cyc=%0d",
                 exp_q[0].cyc, exp_q[0].flg, exp_q[0].w, cyc);
        void'(exp_q.pop_front());
      end
      if (busy || done || err) begin
        n_tests++;
        if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
          n_fail++;
          $display("FAIL unexpected_event: got cyc=%0d busy/done/err=%b w=%b, expected none",
                   cyc, {busy, done, err}, w);
        end else begin
          e = exp_q.pop_front();
          if (e.flg !== {busy, done, err} || e.w !== w) begin
            n_fail++;
            $display("FAIL event: cyc=%0d got busy/done/err=%b w=%b, expected %b w=%b",
                     cyc, {busy, done, err}, w, e.flg, e.w);
          end
        end
      end else begin
        n_tests++;
        if (w !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_w: cyc=%0d got w=%b, expected 0", cyc, w);
        end
      end
    end
  end

  // Issue one start at the current negedge and return at the negedge of the done/err cycle.
  task automatic send(input logic [MAX_LEN-1:0] p, input int l, input int passes, input bit junk);
    int e0, npass, per, last, endc;
    e0 = cyc + 1;
    start      = 1'b1;
    pattern    = p;
    len        = LW'(l);
    repeat_req = 1'b1;
    if (l < 1 || l > MAX_LEN) begin
      push(e0, 3'b001, 1'b0);
      @(negedge clk);
      start = 1'b0;
      return;
    end
    npass = REP_EN ? passes : 1;
    per   = l + GAP;
    for (int ps = 0; ps < npass; ps++) begin
      for (int i = 0; i < l; i++)
        push(e0 + ps * per + i, 3'b100, p[l - 1 - i]);
      if (ps < npass - 1)
        for (int g = 0; g < GAP; g++)
          push(e0 + ps * per + l + g, 3'b100, 1'b0);
    end
    last = e0 + (npass - 1) * per + l - 1;
    endc = last + 1;
    push(endc, 3'b010, 1'b0);
    while (cyc < endc) begin
      @(negedge clk);
      if (cyc < endc) begin
        start      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        pattern    = 8'hFF;
        len        = LW'($urandom_range(0, 15));
        repeat_req = REP_EN ? (cyc < last) : 1'($urandom_range(0, 1));
      end
    end
    start      = 1'b0;
    repeat_req = 1'b0;
  endtask

  initial begin
    int e0;
    reset_n    = 1'b0;
    start      = 1'b0;
    pattern    = '0;
    len        = '0;
    repeat_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send(8'b0000_0101, 3, 1, 1'b0);
    repeat (2) @(negedge clk);

    send(8'b0000_1001, 4, 1, 1'b0);
    send(8'b0000_1001, 4, 1, 1'b0);
    repeat (2) @(negedge clk);

    send(8'h3C, 0, 1, 1'b0);
    @(negedge clk);
    send(8'h3C, MAX_LEN + 1, 1, 1'b0);
    @(negedge clk);
    send(8'h3C, 15, 1, 1'b0);
    @(negedge clk);

    send(8'b0001_0110, 5, 1, 1'b1);
    @(negedge clk);

    send(8'b0000_0101, 3, 3, 1'b0);
    @(negedge clk);

    send(8'h01, 1, 2, 1'b1);
    send(8'hA5, 8, 2, 1'b1);
    @(negedge clk);

    // Reset during bit 2 of an 8-bit frame.
    e0 = cyc + 1;
    start   = 1'b1;
    pattern = 8'hB6;
    len     = LW'(8);
    for (int i = 0; i < 3; i++) push(e0 + i, 3'b100, pattern[7 - i]);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({w, busy, done, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset: got w/busy/done/err=%b, expected 0000", {w, busy, done, err});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    send(8'b0000_0110, 3, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      send(8'($urandom), $urandom_range(0, 10), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
